// File: rtl/ctc_bus_master_pkg.sv
// Shared encodings for the counter/timer channel bus initiator.
// Holds op codes, FSM state encoding, default phase lengths and the
// channel-select decode helper.
package ctc_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_INTACK = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  localparam int DEF_SETUP  = 1;
  localparam int DEF_STROBE = 2;

  // Channel number to one-hot chip select.
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/ctc_bus_master_if.sv
// Command, response and channel-bus signals of the CTC bus initiator.
// master: the initiator's view; slave: the SoC side plus channel side.
// Pure wiring, no state.
interface ctc_bus_master_if #(
  parameter int DWID = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [1:0]      req_chan;
  logic [DWID-1:0] req_data;
  logic            rsp_valid;
  logic [DWID-1:0] rsp_data;
  logic            rsp_err;
  logic            ce_n;
  logic [3:0]      cs;
  logic            m1_n;
  logic            iorq_n;
  logic            rd_n;
  logic [DWID-1:0] bus_dout;
  logic [DWID-1:0] bus_din;
  logic            bus_oe_n;
  logic            int_n;
  logic            int_pending;

  modport master (
    input  req_valid, req_op, req_chan, req_data, bus_din, bus_oe_n, int_n,
    output req_ready, rsp_valid, rsp_data, rsp_err, ce_n, cs, m1_n, iorq_n,
           rd_n, bus_dout, int_pending
  );

  modport slave (
    output req_valid, req_op, req_chan, req_data, bus_din, bus_oe_n, int_n,
    input  req_ready, rsp_valid, rsp_data, rsp_err, ce_n, cs, m1_n, iorq_n,
           rd_n, bus_dout, int_pending
  );
endinterface

// File: rtl/ctc_bus_master_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
// Latency: output follows input after 2 to 3 clk edges.
// No handshake; reset value is a parameter so idle-high inputs stay quiet.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;

  // Shift the asynchronous level through two flops to settle metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/ctc_bus_master.sv
// Turns valid/ready commands into phased Z80-style I/O cycles on the CTC bus.
// Latency: response pulse 1+SETUP+STROBE cycles after accept (1 for reserved op).
// Backpressure: req_ready low from the cycle after accept until the cycle after RECOVER.
module ctc_bus_master
  import ctc_bus_pkg::*;
#(
  parameter int DWID   = 8,
  parameter int SETUP  = DEF_SETUP,
  parameter int STROBE = DEF_STROBE
) (
  input logic clk,
  input logic reset,
  ctc_bus_master_if.master bus
);

  // Read data arrives 2 cycles after RD falls, so shorter strobes are useless.
  if (SETUP < 1 || SETUP > 15 || STROBE < 2 || STROBE > 15) begin : g_bad_params
    $error("ctc_bus_master: SETUP must be 1..15 and STROBE 2..15");
  end

  state_e          state, state_nx;
  op_e             op_q, op_nx;
  logic [1:0]      chan_q, chan_nx;
  logic [DWID-1:0] data_q, data_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            accept;

  logic            captured;
  logic [DWID-1:0] cap_data;
  logic            cap_now, hit, active_nx, rd_like_nx;
  logic [DWID-1:0] eff_data;

  logic            req_ready_q, rsp_valid_q, rsp_err_q;
  logic [DWID-1:0] rsp_data_q, dout_q;
  logic            ce_n_q, m1_n_q, iorq_n_q, rd_n_q;
  logic [3:0]      cs_q;

  logic            req_ready_d, rsp_valid_d, rsp_err_d;
  logic [DWID-1:0] rsp_data_d, dout_d;
  logic            ce_n_d, m1_n_d, iorq_n_d, rd_n_d;
  logic [3:0]      cs_d;

  logic            int_sync;

  // Next-state sequencing plus decode of the next cycle's bus outputs.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    chan_nx  = chan_q;
    data_nx  = data_q;
    accept   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          op_nx   = op_e'(bus.req_op);
          chan_nx = bus.req_chan;
          data_nx = bus.req_data;
          if (op_e'(bus.req_op) == OP_RSVD) begin
            state_nx = ST_RECOVER;
          end else begin
            state_nx = ST_SETUP;
            cnt_nx   = 4'(SETUP - 1);
          end
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = ST_STROBE;
          cnt_nx   = 4'(STROBE - 1);
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          state_nx = ST_RECOVER;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_RECOVER: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase

    // Only the first responder drive in STROBE counts; later cycles are ignored.
    cap_now    = (state == ST_STROBE) && (op_q == OP_READ || op_q == OP_INTACK) &&
                 !bus.bus_oe_n && !captured;
    hit        = captured || cap_now;
    eff_data   = cap_now ? bus.bus_din : cap_data;
    active_nx  = (state_nx == ST_SETUP) || (state_nx == ST_STROBE);
    rd_like_nx = (op_nx == OP_READ) || (op_nx == OP_INTACK);

    req_ready_d = (state_nx == ST_IDLE);
    ce_n_d      = !active_nx;
    cs_d        = active_nx ? onehot4(chan_nx) : 4'b0000;
    dout_d      = active_nx ? data_nx : '0;
    m1_n_d      = !(active_nx && op_nx == OP_INTACK);
    iorq_n_d    = !(state_nx == ST_STROBE);
    rd_n_d      = !(state_nx == ST_STROBE && op_nx == OP_READ);
    rsp_valid_d = (state_nx == ST_RECOVER);
    rsp_err_d   = rsp_valid_d && ((op_nx == OP_RSVD) || (rd_like_nx && !hit));
    rsp_data_d  = (rsp_valid_d && rd_like_nx && hit) ? eff_data : '0;
  end

  // FSM state, phase counter and latched command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      op_q   <= OP_WRITE;
      chan_q <= 2'd0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      op_q   <= op_nx;
      chan_q <= chan_nx;
      data_q <= data_nx;
    end
  end

  // Hold the first captured responder byte for the current command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      captured <= 1'b0;
      cap_data <= '0;
    end else if (accept) begin
      captured <= 1'b0;
      cap_data <= '0;
    end else if (cap_now) begin
      captured <= 1'b1;
      cap_data <= bus.bus_din;
    end
  end

  // Register every output so strobes are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      ce_n_q      <= 1'b1;
      cs_q        <= 4'b0000;
      m1_n_q      <= 1'b1;
      iorq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      dout_q      <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      ce_n_q      <= ce_n_d;
      cs_q        <= cs_d;
      m1_n_q      <= m1_n_d;
      iorq_n_q    <= iorq_n_d;
      rd_n_q      <= rd_n_d;
      dout_q      <= dout_d;
    end
  end

  // Interrupt request is idle-high, so the synchronizer resets to 1.
  sync2 #(.RST_VAL(1'b1)) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.int_n),
    .q     (int_sync)
  );

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.ce_n        = ce_n_q;
  assign bus.cs          = cs_q;
  assign bus.m1_n        = m1_n_q;
  assign bus.iorq_n      = iorq_n_q;
  assign bus.rd_n        = rd_n_q;
  assign bus.bus_dout    = dout_q;
  assign bus.int_pending = !int_sync;

endmodule

// File: tb/tb_ctc_bus_master.sv
// Scoreboard bench for ctc_bus_master with a single CTC channel model.
module tb_ctc_bus_master;
  import ctc_bus_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         io;
    int         rd;
    int         m1;
    int         ce;
    int         good;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ctc_bus_master_if #(.DWID(8)) bus ();

  ctc_bus_master #(.DWID(8), .SETUP(1), .STROBE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [3:0] cur_cs = 4'b0000;
  logic [7:0] cur_dout = 8'h00;

  // Channel model: drives read/vector data from the second strobe cycle,
  // decodes writes as control word (bit0=1, bit2=1 -> time constant follows).
  int         drive_mode = 0;
  logic [7:0] drive_val = 8'h00;
  int         strb_cnt = 0, hi_cnt = 0, last_gap = 0, wr_cnt = 0;
  logic       wr_lo = 1'b0, wait_tc = 1'b0;
  logic [7:0] wr_last = 8'h00, tc = 8'h00;
  logic [7:0] model_out;

  assign model_out    = (drive_mode == 2) ? tc - 8'd1 : drive_val;
  assign bus.bus_oe_n = !(drive_mode != 0 && strb_cnt >= 1 && !bus.iorq_n &&
                          (!bus.rd_n || !bus.m1_n));
  assign bus.bus_din  = bus.bus_oe_n ? 8'h00 : model_out;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!bus.iorq_n) begin
      strb_cnt <= strb_cnt + 1;
      if (hi_cnt != 0) last_gap <= hi_cnt;
      hi_cnt <= 0;
      if (bus.rd_n && bus.m1_n) begin
        wr_lo   <= 1'b1;
        wr_last <= bus.bus_dout;
      end
    end else begin
      strb_cnt <= 0;
      hi_cnt   <= hi_cnt + 1;
      if (wr_lo) begin
        wr_lo  <= 1'b0;
        wr_cnt <= wr_cnt + 1;
        if (wait_tc) begin
          tc      <= wr_last;
          wait_tc <= 1'b0;
        end else if (wr_last[0] && wr_last[2]) begin
          wait_tc <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic err, input int lat,
                              input int io, input int rd, input int m1, input int ce);
    exp_t e;
    e.data = d; e.err = err; e.lat = lat;
    e.io = io; e.rd = rd; e.m1 = m1; e.ce = ce; e.good = ce;
    return e;
  endfunction

  // Monitor: per-transaction strobe accounting, checked when rsp_valid appears.
  int   ce_c = 0, io_c = 0, rd_c = 0, m1_c = 0, good_c = 0, acc_cyc = 0;
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (!bus.ce_n) ce_c++;
      if (!bus.iorq_n) io_c++;
      if (!bus.rd_n) rd_c++;
      if (!bus.m1_n) m1_c++;
      if (!bus.ce_n && bus.cs == cur_cs && bus.bus_dout == cur_dout) good_c++;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, me.data});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, me.err});
          chk("rsp_latency", cyc - acc_cyc, me.lat);
          chk("iorq_low_cycles", io_c, me.io);
          chk("rd_low_cycles", rd_c, me.rd);
          chk("m1_low_cycles", m1_c, me.m1);
          chk("ce_low_cycles", ce_c, me.ce);
          chk("cs_dout_good_cycles", good_c, me.good);
          chk("recover_idle", {16'd0, bus.ce_n, bus.m1_n, bus.iorq_n, bus.rd_n,
                               bus.cs, bus.bus_dout}, 32'h0000_F000);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc = cyc;
        ce_c = 0; io_c = 0; rd_c = 0; m1_c = 0; good_c = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] chan,
                       input logic [7:0] data, input exp_t e);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
      return;
    end
    cur_cs   = (op == OP_RSVD) ? 4'b0000 : (4'b0001 << chan);
    cur_dout = data;
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_chan  = chan;
    bus.req_data  = data;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, rv;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_chan  = 2'd0;
    bus.req_data  = 8'h00;
    bus.int_n     = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp", {22'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
    chk("rst_bus", {16'd0, bus.ce_n, bus.m1_n, bus.iorq_n, bus.rd_n, bus.cs, bus.bus_dout},
        32'h0000_F000);
    chk("rst_int_pending", {31'd0, bus.int_pending}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Control word then time constant back to back, then read the counter.
    drive_mode = 0;
    base = wr_cnt;
    issue(OP_WRITE, 2'd0, 8'h05, mk(8'h00, 1'b0, 4, 2, 0, 0, 3));
    issue(OP_WRITE, 2'd0, 8'h10, mk(8'h00, 1'b0, 4, 2, 0, 0, 3));
    drain();
    chk("two_write_strobes", wr_cnt - base, 2);
    chk("write_gap_ge1", {31'd0, last_gap >= 1}, 32'd1);
    chk("model_tc", {24'd0, tc}, 32'h10);
    drive_mode = 2;
    issue(OP_READ, 2'd0, 8'h00, mk(8'h0F, 1'b0, 4, 2, 2, 0, 3));
    drain();

    // Plain write to channel 2
    drive_mode = 0;
    issue(OP_WRITE, 2'd2, 8'h87, mk(8'h00, 1'b0, 4, 2, 0, 0, 3));
    drain();

    // Read with and without a responder
    drive_mode = 1;
    drive_val  = 8'h5A;
    issue(OP_READ, 2'd1, 8'h00, mk(8'h5A, 1'b0, 4, 2, 2, 0, 3));
    drain();
    drive_mode = 0;
    issue(OP_READ, 2'd3, 8'h00, mk(8'h00, 1'b1, 4, 2, 2, 0, 3));
    drain();

    // Interrupt acknowledge: M1 across setup+strobe, IORQ only in strobe
    drive_mode = 1;
    drive_val  = 8'hE4;
    issue(OP_INTACK, 2'd1, 8'h00, mk(8'hE4, 1'b0, 4, 2, 0, 3, 3));
    drain();

    // Reserved op: immediate error response, no bus activity
    drive_mode = 0;
    issue(OP_RSVD, 2'd0, 8'hAA, mk(8'h00, 1'b1, 1, 0, 0, 0, 0));
    drain();

    // Interrupt synchronizer, both directions
    @(posedge clk); #3;
    bus.int_n = 1'b0;
    n = 0;
    while (!bus.int_pending && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk("int_rise_2to3_edges", {31'd0, (n >= 2 && n <= 3)}, 32'd1);
    @(posedge clk); #3;
    bus.int_n = 1'b1;
    n = 0;
    while (bus.int_pending && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk("int_fall_2to3_edges", {31'd0, (n >= 2 && n <= 3)}, 32'd1);

    // Reset in the middle of a read strobe
    drive_mode = 1;
    drive_val  = 8'h66;
    issue(OP_READ, 2'd0, 8'h00, mk(8'h66, 1'b0, 4, 2, 2, 0, 3));
    @(posedge clk); #1;
    chk("read_strobe_active", {30'd0, bus.iorq_n, bus.rd_n}, 32'd0);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_strobes_high", {29'd0, bus.iorq_n, bus.rd_n, bus.ce_n}, 32'd7);
    chk("rst_no_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) rv++;
    end
    chk("no_rsp_after_reset", rv, 0);
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
    drive_mode = 0;
    issue(OP_WRITE, 2'd3, 8'h33, mk(8'h00, 1'b0, 4, 2, 0, 0, 3));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
